// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the write-back stage state encoding.
package cpu_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results straight to the register file and
// services loads with a single outstanding memory read guarded by a timeout.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int DW      = cpu_pkg::DW,
    parameter int AW      = cpu_pkg::AW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [DW-1:0] ex_result,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_wr,
    input  logic          ex_is_load,
    output logic          mem_req,
    output logic [DW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          rf_wrx,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          pend_valid,
    output logic [AW-1:0] pend_rd,
    output logic          mem_err,
    output logic [15:0]   retired,
    output state_e        state_dbg
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic          accept;
    logic          load_done;
    logic          load_abort;
    logic          ld_wr_q;
    logic [CW-1:0] wait_cnt_q;

    // Handshake: an instruction transfers on a cycle where ex_valid && ex_ready;
    // ex_ready depends only on state, never on ex_valid, and drops while a load waits.
    assign ex_ready   = (state_q == IDLE);
    assign accept     = ex_valid && ex_ready;
    assign state_dbg  = state_q;

    // An ack in the final allowed cycle still completes the load.
    assign load_done  = (state_q == LOAD) && mem_ack;
    assign load_abort = (state_q == LOAD) && !mem_ack && (wait_cnt_q == TO_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && ex_is_load) state_d = LOAD;
            LOAD: if (load_done || load_abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            rf_wrx     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            mem_err    <= 1'b0;
            retired    <= '0;
            ld_wr_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            rf_wrx  <= 1'b0;
            mem_err <= 1'b0;

            if (accept && !ex_is_load) begin
                rf_wrx   <= ex_wr;
                rf_waddr <= ex_rd;
                rf_wdata <= ex_result;
                retired  <= retired + 16'd1;
            end

            // The wait counter reads 1 in the first cycle mem_req is high.
            if (accept && ex_is_load) begin
                mem_req    <= 1'b1;
                mem_addr   <= ex_result;
                pend_valid <= 1'b1;
                pend_rd    <= ex_rd;
                ld_wr_q    <= ex_wr;
                wait_cnt_q <= CW'(1);
            end

            if (load_done) begin
                mem_req    <= 1'b0;
                rf_wrx     <= ld_wr_q;
                rf_waddr   <= pend_rd;
                rf_wdata   <= mem_rdata;
                retired    <= retired + 16'd1;
                pend_valid <= 1'b0;
                wait_cnt_q <= '0;
            end else if (load_abort) begin
                mem_req    <= 1'b0;
                mem_err    <= 1'b1;
                pend_valid <= 1'b0;
                wait_cnt_q <= '0;
            end else if (state_q == LOAD) begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, load/timeout/reset
// sequences, randomized transactions against a transaction-level model.
module tb_wb_stage;
  import cpu_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_result;
  logic [AW-1:0] ex_rd;
  logic          ex_wr;
  logic          ex_is_load;
  logic          mem_req;
  logic [DW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          rf_wrx;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pend_valid;
  logic [AW-1:0] pend_rd;
  logic          mem_err;
  logic [15:0]   retired;
  state_e        state_dbg;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_retired;
  logic [AW+DW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] rd;
    logic          wr;
    logic [DW-1:0] res;
    logic          exp_wrx;
    logic [15:0]   exp_ret;
  } vec_t;
  vec_t tbl[6];

  // clock / reset
  always #5 clk = ~clk;

  wb_stage #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_wrx(rf_wrx), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_rd(pend_rd), .mem_err(mem_err),
    .retired(retired), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && rf_wrx) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rf_write", {rf_waddr, rf_wdata}, 32'hDEAD_0000);
      end else begin
        check("sb_rf_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_wr = 1'b0; ex_rd = '0; ex_result = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    exp_retired = '0;
    exp_q.delete();
    check("rst_ex_ready", ex_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rf", {rf_wrx, rf_waddr, rf_wdata}, 0);
    check("rst_pend", {pend_valid, pend_rd}, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_retired", retired, 0);
    rst = 1'b0;
  endtask

  // driver: one ALU instruction; ex_valid is left high so calls chain back-to-back
  task automatic alu_op(input logic [AW-1:0] rd, input logic wr, input logic [DW-1:0] res);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_wr = wr; ex_result = res;
    check("alu_ex_ready", ex_ready, 1);
    if (wr) exp_q.push_back({rd, res});
    exp_retired = exp_retired + 16'd1;
    tick();
    check("alu_rf_wrx", rf_wrx, wr);
    check("alu_rf_waddr", rf_waddr, rd);
    check("alu_rf_wdata", rf_wdata, res);
    check("alu_retired", retired, exp_retired);
    check("alu_quiet", {mem_req, pend_valid, mem_err}, 0);
  endtask

  // driver: one load acked ack_k cycles after mem_req rises; ack_k >= TIMEOUT means never
  task automatic do_load(input logic [DW-1:0] addr, input logic [AW-1:0] rd, input logic wr,
                         input int ack_k, input logic [DW-1:0] rdata);
    int n;
    bit acked;
    acked = (ack_k < TIMEOUT);
    n = acked ? ack_k + 1 : TIMEOUT;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_wr = wr; ex_result = addr;
    check("ld_ex_ready", ex_ready, 1);
    tick();
    for (int i = 0; i < n; i++) begin
      // blocked instructions while waiting must not be taken
      ex_valid = 1'($urandom_range(0, 1));
      ex_is_load = 1'($urandom_range(0, 1));
      ex_result = DW'($urandom);
      mem_rdata = DW'($urandom);
      check("ld_mem_req", mem_req, 1);
      check("ld_mem_addr", mem_addr, addr);
      check("ld_pend", {pend_valid, pend_rd}, {1'b1, rd});
      check("ld_ex_ready_low", ex_ready, 0);
      check("ld_no_write", {rf_wrx, mem_err}, 0);
      if (acked && i == ack_k) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
        if (wr) exp_q.push_back({rd, rdata});
        exp_retired = exp_retired + 16'd1;
      end
      tick();
      mem_ack = 1'b0;
    end
    ex_valid = 1'b0;
    check("ld_end_mem_req", mem_req, 0);
    check("ld_end_pend_valid", pend_valid, 0);
    check("ld_end_ex_ready", ex_ready, 1);
    check("ld_end_retired", retired, exp_retired);
    if (acked) begin
      check("ld_rf_wrx", rf_wrx, wr);
      check("ld_rf_waddr", rf_waddr, rd);
      check("ld_rf_wdata", rf_wdata, rdata);
      check("ld_mem_err", mem_err, 0);
    end else begin
      check("to_rf_wrx", rf_wrx, 0);
      check("to_mem_err", mem_err, 1);
    end
  endtask

  task automatic idle_cycle(input logic stray_ack);
    ex_valid = 1'b0;
    mem_ack = stray_ack;
    mem_rdata = DW'($urandom);
    tick();
    mem_ack = 1'b0;
    check("idle_rf_wrx", rf_wrx, 0);
    check("idle_mem_req", mem_req, 0);
    check("idle_mem_err", mem_err, 0);
    check("idle_retired", retired, exp_retired);
  endtask

  initial begin
    tbl[0] = '{rd: 4'd3, wr: 1'b1, res: 16'h1234, exp_wrx: 1'b1, exp_ret: 16'd1};
    tbl[1] = '{rd: 4'd1, wr: 1'b1, res: 16'h0001, exp_wrx: 1'b1, exp_ret: 16'd2};
    tbl[2] = '{rd: 4'd2, wr: 1'b1, res: 16'h0002, exp_wrx: 1'b1, exp_ret: 16'd3};
    tbl[3] = '{rd: 4'd3, wr: 1'b1, res: 16'h0003, exp_wrx: 1'b1, exp_ret: 16'd4};
    tbl[4] = '{rd: 4'd0, wr: 1'b1, res: 16'hFFFF, exp_wrx: 1'b1, exp_ret: 16'd5};
    tbl[5] = '{rd: 4'd7, wr: 1'b0, res: 16'h5555, exp_wrx: 1'b0, exp_ret: 16'd6};

    do_reset();

    // back-to-back ALU vectors; ex_ready must stay high throughout
    foreach (tbl[i]) begin
      alu_op(tbl[i].rd, tbl[i].wr, tbl[i].res);
      check("tbl_rf_wrx", rf_wrx, tbl[i].exp_wrx);
      check("tbl_retired", retired, tbl[i].exp_ret);
    end
    idle_cycle(1'b0);

    // loads: spec example, minimum latency, last-cycle ack, timeout, non-writing load
    do_load(16'h0040, 4'd5, 1'b1, 3, 16'hBEEF);
    do_load(16'h0100, 4'd0, 1'b1, 0, 16'hA5A5);
    do_load(16'h0200, 4'd9, 1'b1, TIMEOUT - 1, 16'h1357);
    do_load(16'h0300, 4'd6, 1'b1, TIMEOUT, 16'h0000);
    alu_op(4'd8, 1'b1, 16'h8888);
    do_load(16'h0400, 4'd4, 1'b0, 2, 16'h2468);
    idle_cycle(1'b1);

    // reset in the middle of a load wait; a late ack must be ignored
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd11; ex_wr = 1'b1; ex_result = 16'h0500;
    tick();
    ex_valid = 1'b0;
    tick();
    tick();
    check("mid_ld_mem_req", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_retired = '0;
    check("rst_ld_mem_req", mem_req, 0);
    check("rst_ld_pend", {pend_valid, pend_rd}, 0);
    check("rst_ld_rf_wrx", rf_wrx, 0);
    check("rst_ld_mem_err", mem_err, 0);
    check("rst_ld_ex_ready", ex_ready, 1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // randomized transactions against the transaction-level model
    for (int t = 0; t < 150; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        alu_op(AW'($urandom), ($urandom_range(0, 7) != 0), DW'($urandom));
      end else if (kind < 9) begin
        do_load(DW'($urandom), AW'($urandom), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 4) == 0) ? TIMEOUT + 1 : $urandom_range(0, TIMEOUT - 1),
                DW'($urandom));
      end else begin
        idle_cycle(1'($urandom_range(0, 1)));
      end
    end
    ex_valid = 1'b0;
    idle_cycle(1'b0);

    // retired counter wrap
    do_reset();
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_wr = 1'b0; ex_rd = 4'd2; ex_result = 16'h0;
    repeat (65535) @(posedge clk);
    #1;
    exp_retired = 16'hFFFF;
    check("wrap_pre", retired, exp_retired);
    tick();
    exp_retired = exp_retired + 16'd1;
    check("wrap_zero", retired, 16'h0000);
    check("wrap_model", retired, exp_retired);
    ex_valid = 1'b0;
    tick();

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 4-stage CPU: the last stage, directly upstream of the register file. It accepts retiring instructions from the execute stage, issues a memory read for loads, and drives the register file write port (data, address, write-enable) one cycle after the result is available. It also publishes the pending load destination so decode can detect load-use hazards.

## Interface
- DW, 16, data width (register and memory word)
- AW, 4, register address width (16 registers)
- TIMEOUT, 15, max cycles mem_req is held without mem_ack before abort (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_result  in  DW  ALU result; for loads, the memory address
- ex_rd  in  AW  destination register
- ex_wr  in  1  instruction writes ex_rd
- ex_is_load  in  1  instruction is a load
- mem_req  out  1  memory read request, held until ack or timeout
- mem_addr  out  DW  read address, stable while mem_req=1
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  DW  read data
- rf_wrx  out  1  register file write enable (one-cycle pulse)
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- pend_valid  out  1  load in flight
- pend_rd  out  AW  destination of in-flight load
- mem_err  out  1  one-cycle pulse on load timeout
- retired  out  16  retired instruction count, wrapping

## Operation
- States: IDLE, LOAD. ex_ready = (state==IDLE); combinational from state only.
- Accept = ex_valid & ex_ready.
- Accept, non-load: next cycle rf_wrx=ex_wr, rf_waddr=ex_rd, rf_wdata=ex_result; retired+=1. Stays IDLE; back-to-back accepts allowed every cycle.
- Accept, load: capture ex_rd/ex_wr; next cycle state=LOAD, mem_req=1, mem_addr=ex_result, pend_valid=1, pend_rd=ex_rd.
- LOAD, mem_ack=1: next cycle mem_req=0, rf_wrx=captured ex_wr, rf_waddr=pend_rd, rf_wdata=mem_rdata, retired+=1, state=IDLE, pend_valid=0.
- LOAD, no ack: wait counter increments; when it reaches TIMEOUT with no ack: next cycle mem_req=0, mem_err=1, no RF write, retired unchanged, state=IDLE.
- mem_ack while mem_req=0: ignored.
- All register addresses writable, including 0 (no hardwired zero).
- rf_wrx is 0 in every cycle not listed above; rf_waddr/rf_wdata hold last value.
- retired wraps 16'hFFFF -> 0.

## Timing
- Reset: state=IDLE, ex_ready=1, mem_req=0, mem_addr=0, rf_wrx=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_rd=0, mem_err=0, retired=0, wait counter=0.
- Non-load latency: accept at N -> rf_wrx at N+1.
- Load latency: accept at N -> mem_req N+1..M (M = ack cycle) -> rf_wrx at M+1; ex_ready low N+1..M, high at M+1. Minimum (ack at N+1): RF write at N+2.
- Timeout: mem_req rises at N+1; wait counter is 1 in that cycle; with no ack, abort after mem_req was high for TIMEOUT cycles; mem_err and ex_ready=1 in the following cycle.
- Ack in the same cycle the counter reaches TIMEOUT: ack wins, normal write.
- Reset mid-load: next cycle all reset values; no RF write, no mem_err.
- All outputs registered except ex_ready.

## Structure
- Shared cpu package: DW, AW, state enum (IDLE, LOAD).
- Single module; no sub-module. Wait counter width $clog2(TIMEOUT+1).

## Test plan
- Reset then ex_valid=1, ex_rd=3, ex_wr=1, ex_result=16'h1234, not load -> next cycle rf_wrx=1, rf_waddr=3, rf_wdata=16'h1234, retired=1.
- Three back-to-back ALU ops to r1,r2,r3 -> rf_wrx high three consecutive cycles, ex_ready never drops.
- Load ex_result=16'h0040, ex_rd=5, mem_ack 3 cycles after mem_req with rdata 16'hBEEF -> mem_addr=16'h0040 stable, pend_valid/pend_rd=5 during wait, rf_wdata=16'hBEEF to r5 the cycle after ack, ex_ready low throughout the wait.
- Load, no ack, TIMEOUT=15 -> mem_req high 15 cycles, then mem_err pulse, no RF write, retired unchanged.
- rst asserted during LOAD wait -> next cycle mem_req=0, pend_valid=0, no write; stray mem_ack afterwards ignored.
- retired preloaded to 16'hFFFF via 65535 ops, one more -> retired=0.
